candidate_sorter: RTL

- Upstream stage of `state_machine`.
- Accepts a frame of scored angle candidates (score, theta, phi) one per cycle.
- Keeps the best `DEPTH` candidates in a parallel insertion-sorted register array.
- At end of frame, publishes them as the packed `candidate_angle_buffer` with a one-cycle `sorted_rdy` pulse.
- The published buffer stays stable while the next frame is collected.

---
 rtl/candidate_sorter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/candidate_sorter.sv
// Keeps the best DEPTH scored angle candidates of a frame in a parallel insertion-sorted array.
// Latency: publish two edges after the accepted in_last; in_ready is low outside COLLECT.
// Backpressure: one candidate per cycle while collecting. The optional threshold is enabled by SORT_THRESH_EN.
module candidate_sorter #(
    parameter int DEPTH   = 10,
    parameter int SCORE_W = 16,
    parameter int ANGLE_W = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SCORE_W-1:0]            in_score,
    input  logic [ANGLE_W-1:0]            in_theta,
    input  logic [ANGLE_W-1:0]            in_phi,
    input  logic                          in_last,
    output logic [DEPTH*2*ANGLE_W-1:0]    candidate_angle_buffer,
    output logic [3:0]                    cand_count,
    output logic                          sorted_rdy,
    output logic                          busy
`ifdef SORT_THRESH_EN
    ,
    input  logic [SCORE_W-1:0]            score_min
`endif
);
    localparam int         SLOT_W = 2 * ANGLE_W;
    localparam logic [3:0] FULL   = 4'(DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} state_t;
    state_t state;

    logic [SCORE_W-1:0] w_score  [DEPTH];
    logic [ANGLE_W-1:0] w_theta  [DEPTH];
    logic [ANGLE_W-1:0] w_phi    [DEPTH];
    logic [DEPTH-1:0]   w_valid;
    logic [3:0]         w_count;

    logic [SCORE_W-1:0] up_score [DEPTH];
    logic [ANGLE_W-1:0] up_theta [DEPTH];
    logic [ANGLE_W-1:0] up_phi   [DEPTH];
    logic [DEPTH-1:0]   up_valid;
    logic [DEPTH-1:0]   gt;
    logic [DEPTH-1:0]   gt_prev;
    logic               pass;
    logic               clear_w;
    logic               ins_w;

    always_comb begin
        pass = 1'b1;
`ifdef SORT_THRESH_EN
        pass = (in_score >= score_min);
`endif
        // Slots are contiguous and descending, so gt is a thermometer code; its
        // first set bit is the insertion point and every later set bit shifts down.
        for (int i = 0; i < DEPTH; i++) begin
            gt[i] = !w_valid[i] || (in_score > w_score[i]);
        end
        gt_prev     = gt << 1;
        up_score[0] = '0;
        up_theta[0] = '0;
        up_phi[0]   = '0;
        up_valid[0] = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            up_score[i] = w_score[i-1];
            up_theta[i] = w_theta[i-1];
            up_phi[i]   = w_phi[i-1];
            up_valid[i] = w_valid[i-1];
        end
        clear_w = start && (state == IDLE || state == COLLECT);
        ins_w   = (state == COLLECT) && in_valid && !start && pass;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                  <= IDLE;
            in_ready               <= 1'b0;
            busy                   <= 1'b0;
            sorted_rdy             <= 1'b0;
            cand_count             <= '0;
            candidate_angle_buffer <= '0;
            w_count                <= '0;
            w_valid                <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                w_score[i] <= '0;
                w_theta[i] <= '0;
                w_phi[i]   <= '0;
            end
        end else begin
            sorted_rdy <= 1'b0;

            if (clear_w) begin
                w_count <= '0;
                w_valid <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    w_score[i] <= '0;
                    w_theta[i] <= '0;
                    w_phi[i]   <= '0;
                end
            end else if (ins_w) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (gt[i]) begin
                        if (gt_prev[i]) begin
                            w_score[i] <= up_score[i];
                            w_theta[i] <= up_theta[i];
                            w_phi[i]   <= up_phi[i];
                            w_valid[i] <= up_valid[i];
                        end else begin
                            w_score[i] <= in_score;
                            w_theta[i] <= in_theta;
                            w_phi[i]   <= in_phi;
                            w_valid[i] <= 1'b1;
                        end
                    end
                end
                if (w_count != FULL) begin
                    w_count <= w_count + 4'd1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= COLLECT;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                COLLECT: begin
                    // A discarded in_last still closes the frame; a restart cycle drops its candidate.
                    if (!start && in_valid && in_last) begin
                        state    <= FLUSH;
                        in_ready <= 1'b0;
                    end
                end
                FLUSH: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        candidate_angle_buffer[SLOT_W*i +: SLOT_W] <=
                            w_valid[i] ? {w_theta[i], w_phi[i]} : '0;
                    end
                    cand_count <= w_count;
                    sorted_rdy <= 1'b1;
                    state      <= IDLE;
                    busy       <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule
